serial_addsub_ctrl: RTL and testbench
=====================================

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin one operation.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 selects a+b and 1 selects a-b; it is sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH bits, operand A, sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits, operand B, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port result, output, WIDTH bits, the sum or difference.
REQ-011 The block SHALL have port cout, output, 1 bit, carry out of the MSB; for subtraction cout=1 means no borrow.
REQ-012 The block SHALL have port ovf, output, 1 bit, signed two's-complement overflow.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, using exactly one 1-bit full adder per cycle and a carry flip-flop.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Transitions SHALL be:
- IDLE->RUN on start=1;
- RUN->DONE after WIDTH bit cycles;
- DONE->IDLE unconditionally after one cycle.
REQ-016 When start is sampled in IDLE, the block SHALL load A into a shift register and B^{WIDTH{sub}} into a second shift register, and SHALL set carry=sub.
REQ-017 Each RUN cycle SHALL add the LSBs of both shift registers and the carry, shift the sum bit into the result MSB, shift both operand registers right, and update the carry.
REQ-018 A bit counter SHALL count 0..WIDTH-1 in RUN; the transition to DONE SHALL occur at the edge where counter=WIDTH-1 is processed, with no wrap into an extra cycle.
REQ-019 Latency: if start is sampled at edge k, then busy=1 from edge k to edge k+WIDTH, and done=1 for exactly the one cycle following edge k+WIDTH.
REQ-020 On the final bit, cout SHALL take the carry out and ovf SHALL take (carry into MSB) XOR (carry out of MSB).
REQ-021 result, cout and ovf SHALL hold their values from DONE until the next accepted start, and SHALL NOT change during IDLE.
REQ-022 Start handling outside IDLE:
- start in RUN or DONE SHALL be ignored, not queued;
- a, b and sub changing during RUN SHALL NOT affect the operation in progress.
REQ-023 start held high continuously SHALL begin a new operation on the first IDLE cycle after each DONE, giving a WIDTH+2 cycle repeat period.
REQ-024 result, cout and ovf SHALL be undefined-free (never X) at all times after reset.

Reset
REQ-025 On rst_n=0 the block SHALL immediately, without waiting for a clock, set the state to IDLE, busy=0, done=0, result=0, cout=0, ovf=0, and clear the counter, carry and shift registers.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-027 A shared package addsub_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default width constant.
REQ-028 The 1-bit full adder SHALL be a separate combinational sub-module named fa_bit (inputs x, y, cin; outputs s, co), instantiated once.
REQ-029 The counter width SHALL be $clog2(WIDTH).

Verification (WIDTH=8)
REQ-030 The bench SHALL drive add 0x05+0x03 and require result=0x08, cout=0, ovf=0, with done exactly at edge k+8.
REQ-031 The bench SHALL drive add 0xFF+0x01 and require result=0x00, cout=1, ovf=0; and add 0x7F+0x01 and require result=0x80, ovf=1.
REQ-032 The bench SHALL drive sub 0x05-0x03 and require result=0x02, cout=1; and sub 0x03-0x05 and require result=0xFE, cout=0, ovf=0.
REQ-033 The bench SHALL pulse start with a different a/b at cycles 3 and 8 of RUN, and require that the original result is unaffected and that exactly one done pulse occurs.
REQ-034 The bench SHALL assert rst_n=0 at RUN cycle 4 and require that all outputs are 0 immediately and no done pulse occurs; it SHALL then run 0x10+0x20 and require result=0x30.
REQ-035 The bench SHALL hold start=1 for three operations and require done pulses spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder; the only arithmetic element in the serial datapath.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: LSB first, one full-adder step per RUN cycle.
//   state | meaning
//   IDLE  | waiting for start; result/cout/ovf hold the last answer
//   RUN   | one bit per cycle, WIDTH cycles
//   DONE  | one-cycle done pulse, then back to IDLE
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  addsub_state_t    state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;
  logic             last;

  assign last = (cnt == LAST);

  fa_bit u_fa (
    .x   (sa[0]),
    .y   (sb[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      sa    <= a;
      sb    <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      carry  <= fa_co;
      result <= {fa_s, result[WIDTH-1:1]};
      if (last) begin
        cnt  <= '0;
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each done pulse.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           at;
  } exp_t;

  exp_t q[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done at cycle %0d res=%h, required no done", cyc, result);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (result !== e.res || cout !== e.co || ovf !== e.ov || cyc != e.at) begin
          n_err++;
          $display("FAIL %s: got res=%h cout=%b ovf=%b cycle=%0d, required res=%h cout=%b ovf=%b cycle=%0d",
                   e.tag, result, cout, ovf, cyc, e.res, e.co, e.ov, e.at);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [W-1:0] r, input logic co,
                          input logic ov, input int at);
    exp_t e;
    e.tag = tag; e.res = r; e.co = co; e.ov = ov; e.at = at;
    q.push_back(e);
  endtask

  // Called just after a negedge; start is sampled at edge k, returns at the negedge after it.
  task automatic issue(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic [W-1:0] er, input logic eco,
                       input logic eov, input logic push, output int k);
    a = ia; b = ib; sub = isub; start = 1'b1;
    k = cyc + 1;
    if (push) push_exp(tag, er, eco, eov, k + W);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d results pending, required 0", tag, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #3;
    check("reset_outs", {27'd0, busy, done, cout, ovf, 1'b0} | {24'd0, result}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, k);
    drain("add_05_03", 20);
    issue("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, k);
    drain("add_ff_01", 20);
    issue("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, k);
    drain("add_7f_01", 20);
    issue("sub_05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, k);
    drain("sub_05_03", 20);
    issue("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, k);
    drain("sub_03_05", 20);

    // start pulses and operand changes during RUN must be ignored
    issue("ignore_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, k);
    while (cyc < k + 2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hAA;
    while (cyc < k + 7) @(negedge clk);
    start = 1'b1; b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    drain("ignore_start", 20);
    repeat (4) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_hold", {22'd0, cout, ovf, result}, {22'd0, 1'b0, 1'b0, 8'h46});

    // reset during RUN cycle 4 aborts with no done pulse
    issue("abort", 8'h55, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, k);
    while (cyc < k + 3) @(negedge clk);
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {27'd0, busy, done, cout, ovf, 1'b0} | {24'd0, result}, 32'd0);
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, k);
    drain("add_10_20", 20);

    // start held high: done pulses W+2 cycles apart
    a = 8'h21; b = 8'h13; sub = 1'b0; start = 1'b1;
    k = cyc + 1;
    push_exp("held_1", 8'h34, 1'b0, 1'b0, k + W);
    push_exp("held_2", 8'h34, 1'b0, 1'b0, k + W + 10);
    push_exp("held_3", 8'h34, 1'b0, 1'b0, k + W + 20);
    while (cyc < k + 22) @(negedge clk);
    start = 1'b0;
    drain("held", 40);
    repeat (12) @(negedge clk);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
